// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register carrying PC, payload, exception code, valid and branch-delay flag.
// Define PIPE_STAT_EN to build the saturating stall/bubble counters; otherwise they read as zero.
module pipe_stage_reg #(
  parameter int unsigned PAY_W      = 32,
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [4:0]  KILL_CODE  = 5'd4,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             req,
  input  logic             eret_clr,
  input  logic [31:0]      epc_in,
  input  logic             flush,
  input  logic [31:0]      in_pc,
  input  logic [PAY_W-1:0] in_payload,
  input  logic [4:0]       in_exccode,
  input  logic             in_valid,
  input  logic             prev_is_jump,
  output logic [31:0]      out_pc,
  output logic [PAY_W-1:0] out_payload,
  output logic [4:0]       out_exccode,
  output logic             out_valid,
  output logic             out_bd,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  logic [31:0]      pc_q, pc_d;
  logic [PAY_W-1:0] payload_q, payload_d;
  logic [4:0]       exccode_q, exccode_d;
  logic             valid_q, valid_d;
  logic             bd_q, bd_d;
  logic             do_flush, do_hold;

  // Redirects outrank the bubble, which outranks a normal advance.
  assign do_flush = !req && !eret_clr && flush;
  assign do_hold  = !req && !eret_clr && !flush && !en;

  always_comb begin
    pc_d      = pc_q;
    payload_d = payload_q;
    exccode_d = exccode_q;
    valid_d   = valid_q;
    bd_d      = bd_q;
    if (req) begin
      pc_d      = HANDLER_PC;
      payload_d = '0;
      exccode_d = '0;
      valid_d   = 1'b0;
      bd_d      = 1'b0;
    end else if (eret_clr) begin
      pc_d      = epc_in;
      payload_d = '0;
      exccode_d = '0;
      valid_d   = 1'b0;
      bd_d      = 1'b0;
    end else if (flush) begin
      // The bubble keeps its PC so an exception reported against it has a sane EPC.
      pc_d      = in_pc;
      payload_d = '0;
      exccode_d = '0;
      valid_d   = 1'b0;
      bd_d      = prev_is_jump;
    end else if (en) begin
      pc_d      = in_pc;
      payload_d = (in_exccode == KILL_CODE) ? '0 : in_payload;
      exccode_d = in_exccode;
      valid_d   = in_valid;
      bd_d      = prev_is_jump;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      payload_q <= '0;
      exccode_q <= '0;
      valid_q   <= 1'b0;
      bd_q      <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      payload_q <= payload_d;
      exccode_q <= exccode_d;
      valid_q   <= valid_d;
      bd_q      <= bd_d;
    end
  end

  assign out_pc      = pc_q;
  assign out_payload = payload_q;
  assign out_exccode = exccode_q;
  assign out_valid   = valid_q;
  assign out_bd      = bd_q;

`ifdef PIPE_STAT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (do_hold && valid_q && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (do_flush && (bubble_cnt_q != '1)) begin
      bubble_cnt_d = bubble_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`else
  logic unused_stat;
  assign unused_stat = do_flush ^ do_hold;
  assign stall_cnt   = '0;
  assign bubble_cnt  = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg; expectations track PIPE_STAT_EN.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic        en, req, eret_clr, flush, in_valid, prev_is_jump;
  logic [31:0] epc_in, in_pc, in_payload;
  logic [4:0]  in_exccode;
  logic [31:0] out_pc, out_payload;
  logic [4:0]  out_exccode;
  logic        out_valid, out_bd;
  logic [31:0] stall_cnt, bubble_cnt;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef PIPE_STAT_EN
  localparam bit Stat = 1'b1;
`else
  localparam bit Stat = 1'b0;
`endif

  pipe_stage_reg dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .req          (req),
    .eret_clr     (eret_clr),
    .epc_in       (epc_in),
    .flush        (flush),
    .in_pc        (in_pc),
    .in_payload   (in_payload),
    .in_exccode   (in_exccode),
    .in_valid     (in_valid),
    .prev_is_jump (prev_is_jump),
    .out_pc       (out_pc),
    .out_payload  (out_payload),
    .out_exccode  (out_exccode),
    .out_valid    (out_valid),
    .out_bd       (out_bd),
    .stall_cnt    (stall_cnt),
    .bubble_cnt   (bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_pc"}, 64'(out_pc), 64'h3000);
    check_eq({tag, "_pay"}, 64'(out_payload), 64'h0);
    check_eq({tag, "_exc"}, 64'(out_exccode), 64'h0);
    check_eq({tag, "_valid"}, 64'(out_valid), 64'h0);
    check_eq({tag, "_bd"}, 64'(out_bd), 64'h0);
    check_eq({tag, "_stall"}, 64'(stall_cnt), 64'h0);
    check_eq({tag, "_bubble"}, 64'(bubble_cnt), 64'h0);
  endtask

  initial begin
    reset = 1'b1;
    {en, req, eret_clr, flush, in_valid, prev_is_jump} = '0;
    epc_in = '0; in_pc = '0; in_payload = '0; in_exccode = '0;
    step();
    step();
    check_reset_state("rst");
    reset = 1'b0;

    // First load
    en = 1'b1; in_pc = 32'h3000; in_payload = 32'h2408_0005; in_valid = 1'b1;
    step();
    check_eq("load_pc", 64'(out_pc), 64'h3000);
    check_eq("load_pay", 64'(out_payload), 64'h2408_0005);
    check_eq("load_valid", 64'(out_valid), 64'h1);
    check_eq("load_bd", 64'(out_bd), 64'h0);

    // Stall for three edges while inputs keep changing
    in_pc = 32'h3004; in_payload = 32'h1111_1111;
    step();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_pc = 32'h3100 + 32'(i); in_payload = 32'hAAAA_0000 + 32'(i); in_valid = i[0];
      prev_is_jump = 1'b1;
      step();
    end
    check_eq("stall_pc", 64'(out_pc), 64'h3004);
    check_eq("stall_pay", 64'(out_payload), 64'h1111_1111);
    check_eq("stall_valid", 64'(out_valid), 64'h1);
    check_eq("stall_bd", 64'(out_bd), 64'h0);
    check_eq("stall_cnt3", 64'(stall_cnt), Stat ? 64'd3 : 64'd0);

    // KILL_CODE squashes payload; other codes do not
    en = 1'b1; prev_is_jump = 1'b0; in_valid = 1'b1;
    in_pc = 32'h300C; in_exccode = 5'd4; in_payload = 32'hFFFF_FFFF;
    step();
    check_eq("kill_pay", 64'(out_payload), 64'h0);
    check_eq("kill_exc", 64'(out_exccode), 64'd4);
    in_exccode = 5'd12;
    step();
    check_eq("nokill_pay", 64'(out_payload), 64'hFFFF_FFFF);
    check_eq("nokill_exc", 64'(out_exccode), 64'd12);

    // All events at once: req wins
    req = 1'b1; eret_clr = 1'b1; epc_in = 32'h3010; flush = 1'b1; prev_is_jump = 1'b1;
    step();
    check_eq("req_pc", 64'(out_pc), 64'h4180);
    check_eq("req_pay", 64'(out_payload), 64'h0);
    check_eq("req_exc", 64'(out_exccode), 64'h0);
    check_eq("req_valid", 64'(out_valid), 64'h0);
    check_eq("req_bd", 64'(out_bd), 64'h0);
    req = 1'b0; flush = 1'b0; en = 1'b0;
    step();
    check_eq("eret_pc", 64'(out_pc), 64'h3010);
    check_eq("eret_valid", 64'(out_valid), 64'h0);
    check_eq("eret_bd", 64'(out_bd), 64'h0);
    check_eq("eret_bubble", 64'(bubble_cnt), 64'h0);
    check_eq("eret_stall", 64'(stall_cnt), Stat ? 64'd3 : 64'd0);

    // Flush while stalled: PC and BD taken, exccode 4 must not matter
    eret_clr = 1'b0; flush = 1'b1; en = 1'b0; in_pc = 32'h3020; prev_is_jump = 1'b1;
    in_payload = 32'h5555_5555; in_exccode = 5'd4; in_valid = 1'b1;
    step();
    check_eq("flush_pc", 64'(out_pc), 64'h3020);
    check_eq("flush_bd", 64'(out_bd), 64'h1);
    check_eq("flush_valid", 64'(out_valid), 64'h0);
    check_eq("flush_pay", 64'(out_payload), 64'h0);
    check_eq("flush_exc", 64'(out_exccode), 64'h0);
    check_eq("flush_bubble", 64'(bubble_cnt), Stat ? 64'd1 : 64'd0);

    // Load in a delay slot, then stall twice with a valid entry
    flush = 1'b0; en = 1'b1; in_pc = 32'h3024; in_payload = 32'h1234_5678;
    in_exccode = 5'd0; prev_is_jump = 1'b1;
    step();
    check_eq("bd_pc", 64'(out_pc), 64'h3024);
    check_eq("bd_bd", 64'(out_bd), 64'h1);
    check_eq("bd_pay", 64'(out_payload), 64'h1234_5678);
    en = 1'b0; prev_is_jump = 1'b0;
    step();
    step();
    check_eq("stall_cnt5", 64'(stall_cnt), Stat ? 64'd5 : 64'd0);
    check_eq("bubble_hold", 64'(bubble_cnt), Stat ? 64'd1 : 64'd0);

    // Asynchronous reset between edges during the stall
    #2;
    reset = 1'b1;
    #1;
    check_reset_state("arst");
    #1;
    reset = 1'b0;
    en = 1'b1; in_pc = 32'h3030; in_payload = 32'h0000_00AB; prev_is_jump = 1'b0;
    step();
    check_eq("post_rst_pc", 64'(out_pc), 64'h3030);
    check_eq("post_rst_pay", 64'(out_payload), 64'hAB);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register for the five-stage MIPS core, replacing the hand-written fetch/decode register with one block instantiable between any two stages. Each entry carries PC, a generic payload, exception code, a valid bit and a branch-delay flag. It supports four events: stall, bubble insertion, exception redirect and eret redirect. Optional saturating stall and bubble counters feed performance debug.

## Interface
Parameters:
- PAY_W, 32: payload width (instruction word, or packed control bundle in later stages).
- RESET_PC, 32'h0000_3000: out_pc value after reset.
- HANDLER_PC, 32'h0000_4180: out_pc value loaded on req.
- KILL_CODE, 5'd4: in_exccode value whose payload is squashed to zero on load.
- CNT_W, 32: statistics counter width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  advance enable; 0 = stall (hold).
- req  in  1  exception/interrupt taken this cycle.
- eret_clr  in  1  eret committing; redirect to epc_in.
- epc_in  in  32  return address from CP0.
- flush  in  1  insert bubble.
- in_pc  in  32  upstream PC.
- in_payload  in  PAY_W  upstream payload.
- in_exccode  in  5  upstream exception code (0 = none).
- in_valid  in  1  upstream entry is a real instruction.
- prev_is_jump  in  1  upstream-of-upstream is a branch/jump (next-PC select non-zero); source of BD.
- out_pc  out  32  registered PC.
- out_payload  out  PAY_W  registered payload.
- out_exccode  out  5  registered exception code.
- out_valid  out  1  registered valid.
- out_bd  out  1  entry sits in a branch delay slot.
- stall_cnt  out  CNT_W  cycles held with a valid entry.
- bubble_cnt  out  CNT_W  bubbles inserted.

## Operation
Each rising edge applies exactly one action, in this priority order:
1. **req**: out_pc←HANDLER_PC; payload, exccode, valid and bd←0.
2. **eret_clr** (req=0): out_pc←epc_in; payload, exccode, valid and bd←0.
3. **flush** (applied regardless of en):
   - out_pc←in_pc. The bubble keeps its PC so a later exception on it reports a sane EPC.
   - out_bd←prev_is_jump.
   - payload, exccode and valid←0.
4. **en=1**:
   - out_pc←in_pc; out_exccode←in_exccode; out_valid←in_valid; out_bd←prev_is_jump.
   - out_payload←0 if in_exccode==KILL_CODE, else in_payload.
5. **Otherwise**: all registers hold.

Other rules:
- Reset values: out_pc=RESET_PC; out_payload=0, out_exccode=0, out_valid=0, out_bd=0; counters=0.
- eret_clr and req together: req wins; epc_in is ignored.
- KILL_CODE squashing applies only on a normal load, never on flush.

## Timing
- One-cycle latency: inputs sampled at edge N appear on outputs after edge N and stay until the next loading event.
- All outputs are registered; no combinational input→output path.
- reset clears outputs immediately on assertion, independent of clk. The first loading edge is the first rising edge after deassertion.
- A stall lasting any number of cycles holds all outputs bit-exact.
- Reset asserted mid-stall or mid-flush: reset values win immediately.

## Configuration
PIPE_STAT_EN:
- **Defined**:
  - stall_cnt increments on every edge where action 5 (hold) occurs with out_valid=1.
  - bubble_cnt increments on every edge where action 3 (flush) occurs.
  - Both counters saturate at all-ones and do not wrap.
  - req and eret_clr cycles count in neither counter.
- **Undefined**: counter logic is not built; stall_cnt and bubble_cnt are tied to 0. Ports stay present so instantiations are identical either way.

## Test plan
- Reset then release, en=1, in_pc=0x3000, in_payload=0x2408_0005, in_valid=1, prev_is_jump=0 → one edge later out_pc=0x3000, out_payload=0x2408_0005, out_valid=1, out_bd=0.
- Load in_pc=0x3004, then en=0 for 3 edges while inputs change → outputs hold 0x3004 / old payload; with PIPE_STAT_EN, stall_cnt=3.
- en=1 with in_exccode=4, in_payload=0xFFFF_FFFF → out_payload=0, out_exccode=4; same with in_exccode=12 → out_payload=0xFFFF_FFFF.
- req, eret_clr (epc_in=0x3010), flush and en all =1 together → out_pc=0x4180, all other fields 0; next edge with only eret_clr=1 → out_pc=0x3010.
- flush=1, en=0, in_pc=0x3020, prev_is_jump=1 → out_pc=0x3020, out_bd=1, out_valid=0, out_payload=0; bubble_cnt=1 with the macro, 0 without.
- Assert reset asynchronously between edges during a stall → outputs immediately show out_pc=0x3000, all other fields 0, counters 0.
